uart_rx: RTL and testbench

Serial receive front end for the host link. Oversamples the asynchronous `rx` pin, recovers 8N1 frames and presents each byte on `data_out` with a `valid` flag held until the command controller acknowledges it with `get`. Its `data_out`/`valid` pair drives the controller's `data_in`/`in` inputs directly. The controller drives `get` combinationally from `in`, so a held byte is consumed the cycle it appears. Line errors and overruns are flagged as single-cycle pulses.

---
 rtl/uart_rx.sv | 133 +++++++++++++
 tb/tb_uart_rx.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises rx, samples each bit at its centre and
// hands bytes to the consumer through a valid/get holding register.
//
// state   | meaning
// S_IDLE  | line idle, waiting for rx_s low
// S_START | timing to start-bit centre, rejecting glitches
// S_DATA  | sampling 8 data bits, LSB first
// S_STOP  | sampling stop bit, delivering or flagging framing error
// S_BREAK | line held low after a framing error, waiting for high
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       rx,
  input  logic       get,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t      state, state_n;
  logic        rx_m, rx_s;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  idx, idx_n;
  logic [7:0]  shreg, shreg_n, data_n;
  logic        valid_n, ferr_n, ovr_n, deliver;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      idx       <= 3'd0;
      shreg     <= 8'h00;
      data_out  <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      shreg     <= shreg_n;
      data_out  <= data_n;
      valid     <= valid_n;
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    shreg_n = shreg;
    data_n  = data_out;
    valid_n = valid;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;
    deliver = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_n = 16'd0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        cnt_n = cnt + 16'd1;
        if (cnt == HALF_LAST) begin
          cnt_n   = 16'd0;
          idx_n   = 3'd0;
          state_n = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        cnt_n = cnt + 16'd1;
        if (cnt == BIT_LAST) begin
          cnt_n        = 16'd0;
          shreg_n[idx] = rx_s;
          idx_n        = idx + 3'd1;
          if (idx == 3'd7) state_n = S_STOP;
        end
      end
      S_STOP: begin
        cnt_n = cnt + 16'd1;
        if (cnt == BIT_LAST) begin
          cnt_n = 16'd0;
          if (rx_s) begin
            deliver = 1'b1;
            state_n = S_IDLE;
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_n = 16'd0;
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // A same-cycle get frees the holding register, so the new byte replaces it
    if (deliver) begin
      if (!valid || get) begin
        data_n  = shreg;
        valid_n = 1'b1;
      end else begin
        ovr_n = 1'b1;
      end
    end else if (get) begin
      valid_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and random frames for uart_rx, checked every cycle against a
// frame-level model of the delivery rules.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       nRst, rx, get, get_drv, get_tie;
  logic [7:0] data_out;
  logic       valid, frame_err, overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_data;
  logic       m_valid, m_ferr, m_ovr;

  assign get = get_tie ? valid : get_drv;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk      (clk),
    .nRst     (nRst),
    .rx       (rx),
    .get      (get),
    .data_out (data_out),
    .valid    (valid),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock period: compare outputs, drive inputs for the coming edge,
  // then advance the model to what that edge must produce.
  task automatic step(input logic r, input logic nr, input int gm,
                      input bit stop_edge, input logic stop_val, input logic [7:0] b);
    logic g;
    @(negedge clk);
    check("data_out", data_out, m_data);
    check("valid", 8'(valid), 8'(m_valid));
    check("frame_err", 8'(frame_err), 8'(m_ferr));
    check("overrun", 8'(overrun), 8'(m_ovr));
    rx      = r;
    nRst    = nr;
    get_drv = (gm == 2) ? 1'($urandom_range(0, 1)) : (gm != 0);
    m_ferr  = 1'b0;
    m_ovr   = 1'b0;
    if (!nr) begin
      #1;
      check("rst_data", data_out, 8'h00);
      check("rst_valid", 8'(valid), 8'h00);
      check("rst_ferr", 8'(frame_err), 8'h00);
      check("rst_ovr", 8'(overrun), 8'h00);
      m_data  = 8'h00;
      m_valid = 1'b0;
    end else begin
      g = get_tie ? m_valid : get_drv;
      if (stop_edge) begin
        if (stop_val) begin
          if (!m_valid || g) begin
            m_data  = b;
            m_valid = 1'b1;
          end else begin
            m_ovr = 1'b1;
          end
        end else begin
          m_ferr = 1'b1;
        end
      end else if (m_valid && g) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n, input int gm);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, gm, 1'b0, 1'b1, 8'h00);
  endtask

  task automatic hold_low(input int n, input int gm);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, gm, 1'b0, 1'b1, 8'h00);
  endtask

  // Frame starts at local cycle 0; the stop bit is sampled on the edge after cycle 154.
  task automatic send_frame(input logic [7:0] b, input logic stopv, input int gm, input int rst_at);
    for (int c = 0; c < 10 * CPB; c++) begin
      logic r, nr;
      if (c < CPB) r = 1'b0;
      else if (c < 9 * CPB) r = b[(c - CPB) / CPB];
      else r = stopv;
      nr = !(rst_at >= 0 && c >= rst_at && c < rst_at + 3);
      step(r, nr, gm, (c == 9 * CPB + CPB / 2 + 2) && (rst_at < 0), stopv, b);
    end
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    nRst = 1'b0; rx = 1'b1; get_drv = 1'b0; get_tie = 1'b0;
    m_data = 8'h00; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 0, 1'b0, 1'b1, 8'h00);
    idle(5, 0);

    send_frame(8'hA5, 1'b1, 0, -1);
    check("a5_data", data_out, 8'hA5);
    check("a5_valid", 8'(valid), 8'h01);
    idle(10, 0);
    idle(1, 1);
    idle(5, 0);
    check("a5_cleared", 8'(valid), 8'h00);

    hold_low(4, 0);
    idle(20, 0);
    check("glitch_valid", 8'(valid), 8'h00);
    send_frame(8'h3C, 1'b1, 0, -1);
    check("3c_data", data_out, 8'h3C);
    idle(1, 1);
    idle(5, 0);

    send_frame(8'h3C, 1'b0, 0, -1);
    hold_low(40, 0);
    idle(20, 0);
    check("break_valid", 8'(valid), 8'h00);

    send_frame(8'h11, 1'b1, 0, -1);
    send_frame(8'h22, 1'b1, 0, -1);
    check("ovr_keep", data_out, 8'h11);
    idle(1, 1);
    idle(5, 0);

    get_tie = 1'b1;
    send_frame(8'h11, 1'b1, 0, -1);
    send_frame(8'h22, 1'b1, 0, -1);
    idle(5, 0);
    check("tie_data", data_out, 8'h22);
    get_tie = 1'b0;

    send_frame(8'h77, 1'b1, 0, -1);
    idle(3, 0);
    send_frame(8'hFF, 1'b1, 0, 5 * CPB + 5);
    idle(20, 0);
    check("post_rst_valid", 8'(valid), 8'h00);
    send_frame(8'h5A, 1'b1, 0, -1);
    check("5a_data", data_out, 8'h5A);
    idle(1, 1);
    idle(3, 0);

    for (int k = 0; k < 20; k++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 7) != 0);
      send_frame(rb, rs, 2, -1);
      idle(rs ? $urandom_range(0, 5) : $urandom_range(4, 8), 2);
    end
    idle(10, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
